// File: rtl/memory_gateway_pkg.sv
// rtl/memory_gateway_pkg.sv - shared types and widths for the memory gateway driver
package memory_gateway_pkg;

  localparam int MEM_DATA_WIDTH = 16;
  localparam int GW_ADDR_WIDTH  = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} driver_state_t;

  // Address is stored already zero-extended to the gateway width.
  typedef struct packed {
    logic [GW_ADDR_WIDTH-1:0]  addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic                      wen;
  } mem_req_t;

endpackage

// File: rtl/memory_gateway_driver_if.sv
// rtl/memory_gateway_driver_if.sv - core request/response and gateway handshake bundle
interface memory_gateway_driver_if #(
  parameter int ADDR_WIDTH = 64
);
  import memory_gateway_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [MEM_DATA_WIDTH-1:0] req_wdata;
  logic                      req_wen;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [MEM_DATA_WIDTH-1:0] resp_rdata;

  logic                      gw_ap_start;
  logic                      gw_ap_done;
  logic [MEM_DATA_WIDTH-1:0] gw_ap_return;
  logic [GW_ADDR_WIDTH-1:0]  gw_addr;
  logic [MEM_DATA_WIDTH-1:0] gw_wdata;
  logic                      gw_wen;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wen, resp_ready, gw_ap_done, gw_ap_return,
    output req_ready, resp_valid, resp_rdata, gw_ap_start, gw_addr, gw_wdata, gw_wen
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wen, resp_ready, gw_ap_done, gw_ap_return,
    input  req_ready, resp_valid, resp_rdata, gw_ap_start, gw_addr, gw_wdata, gw_wen
  );

endinterface

// File: rtl/memory_request_fifo.sv
// rtl/memory_request_fifo.sv - in-order request buffer with extra-bit wrap pointers
module memory_request_fifo
  import memory_gateway_pkg::*;
#(
  parameter type entry_t = mem_req_t,
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  entry_t      mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PW-1:0]] <= push_data;
  end

  // Same index with differing wrap bits means the write pointer lapped the read pointer.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/memory_gateway_driver.sv
// rtl/memory_gateway_driver.sv - buffers core word requests and issues them one at a time over ap_start/ap_done
module memory_gateway_driver
  import memory_gateway_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [GW_ADDR_WIDTH-1:0] base_pointer,
  output logic [GW_ADDR_WIDTH-1:0] gw_memory_pointer,
  output logic                     busy,
  output logic                     timeout_error,
  memory_gateway_driver_if.master  bus
);

  driver_state_t             state;
  driver_state_t             state_next;
  logic                      live;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      head_active;
  mem_req_t                  req_in;
  mem_req_t                  head;
  logic [31:0]               wait_cnt;
  logic [31:0]               wait_cnt_inc;
  logic [MEM_DATA_WIDTH-1:0] rdata;

  assign gw_memory_pointer = base_pointer;

  assign req_in = '{addr:  64'(bus.req_addr[ADDR_WIDTH-1:0]),
                    wdata: bus.req_wdata,
                    wen:   bus.req_wen};

  // live keeps req_ready low while reset is asserted, without a combinational reset path.
  assign bus.req_ready = live && !full;
  assign push          = bus.req_valid && bus.req_ready;

  memory_request_fifo #(
    .entry_t (mem_req_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (push),
    .push_data (req_in),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:  if (!empty) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (bus.gw_ap_done) begin
          pop        = 1'b1;
          state_next = head.wen ? IDLE : RESP;
        end
      end
      RESP:  if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 32'd1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      live          <= 1'b0;
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
      rdata         <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_next;
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !bus.gw_ap_done) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == 32'(TIMEOUT_CYCLES - 1))
          timeout_error <= 1'b1;
      end
      // gw_ap_return is only meaningful in the ap_done cycle, so capture it there.
      if (state == WAIT && bus.gw_ap_done && !head.wen)
        rdata <= bus.gw_ap_return;
    end
  end

  assign head_active     = (state == ISSUE) || (state == WAIT);
  assign bus.gw_ap_start = (state == ISSUE);
  assign bus.gw_addr     = head_active ? head.addr  : '0;
  assign bus.gw_wdata    = head_active ? head.wdata : '0;
  assign bus.gw_wen      = head_active ? head.wen   : 1'b0;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_rdata  = (state == RESP) ? rdata : '0;
  assign busy            = !empty || (state != IDLE);

endmodule

// File: doc/memory_gateway_driver.md
Name: memory_gateway_driver

Overview:
- Upstream stage of the memory gateway. Accepts 16-bit word read/write requests from the core side over a valid/ready interface and buffers them in a small in-order FIFO.
- Issues requests one at a time to the gateway's ap_start/ap_done protocol, holding address, data and write-enable stable.
- Captures ap_return in the single ap_done cycle of a read and presents it as a registered read response with backpressure.
- Flags a sticky timeout if the gateway never completes.

Parameters:
- ADDR_WIDTH, 64, width of word address (zero-extended to 64 on gateway side).
- FIFO_DEPTH, 4, request buffer entries; power of two, >= 2.
- TIMEOUT_CYCLES, 1024, cycles in WAIT without ap_done before timeout_error sets.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- base_pointer  in  64  memory base, passed combinationally to gw_memory_pointer.
- req_valid  in  1  core request valid.
- req_ready  out  1  high when FIFO not full.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  16  write data.
- req_wen  in  1  1 = write, 0 = read.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  16  read data.
- gw_ap_start  out  1  gateway start strobe.
- gw_ap_done  in  1  gateway completion, one-cycle pulse.
- gw_ap_return  in  16  gateway read data, valid only with gw_ap_done.
- gw_memory_pointer  out  64  = base_pointer.
- gw_addr  out  64  head request address, zero-extended.
- gw_wdata  out  16  head request write data.
- gw_wen  out  1  head request write enable.
- busy  out  1  FIFO non-empty or state != IDLE.
- timeout_error  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync deassert by system): FIFO empty, state IDLE, timeout counter 0. All outputs 0 except gw_memory_pointer, which follows base_pointer. Reset mid-operation abandons the in-flight request and all buffered entries; no response is produced.
- Push: a request enters the FIFO on an edge with req_valid & req_ready. req_ready = !full only; there is no bypass. A push and pop in the same cycle when full is not possible because ready is low.
- gw_addr, gw_wdata and gw_wen are driven from the FIFO head whenever state is ISSUE or WAIT. They hold stable from ISSUE until the head pops; they are 0 in IDLE/RESP.
- FSM:
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE: gw_ap_start = 1 for exactly this cycle; clear timeout counter -> WAIT.
  - WAIT: on gw_ap_done with a write, pop head -> IDLE. On gw_ap_done with a read, register gw_ap_return into resp_rdata and pop head -> RESP. Otherwise increment counter (saturating, 32-bit); when it reaches TIMEOUT_CYCLES-1, set timeout_error and keep waiting.
  - RESP: resp_valid = 1 and resp_rdata held until resp_ready. On the handshake edge -> IDLE (resp_valid low next cycle).
- gw_ap_done in any state other than WAIT is ignored.
- Writes generate no response. Ordering is strictly in request order.
- timeout_error clears only on reset.
- Latency: a read handshaken in cycle 0 into an empty FIFO gives gw_ap_start in cycle 2. With gateway latency L, gw_ap_done arrives in cycle L+3 and resp_valid in cycle L+4.
- Throughput: one request per (L+3) cycles for writes, plus RESP occupancy for reads.

Decomposition:
- Package memory_gateway_pkg holds:
  - driver_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - mem_req_t packed struct {addr, wdata, wen}.
  - MEM_DATA_WIDTH = 16.
- Sub-module memory_request_fifo: parameterised on mem_req_t and FIFO_DEPTH, with push/pop/full/empty/head ports and wrapping pointers plus an extra bit for full/empty disambiguation.

Test Plan:
- Single read, addr 0x10, gateway model returns 0xBEEF at latency 77 -> gw_ap_start cycle 2 with gw_addr=0x10, gw_wen=0; resp_valid cycle 81 with resp_rdata=0xBEEF.
- Write 0x1234 to addr 5 then read addr 5 back-to-back -> two gw_ap_start pulses, write first; no response for the write; read response 0x1234; gw_wdata stable through the write's WAIT.
- Push 5 requests with resp_ready=1 and gateway stalled -> req_ready low after the 4th accepted; 5th is accepted only after the first completion; issue order matches request order.
- Read completes with resp_ready=0 for 10 cycles -> resp_valid and resp_rdata held for all 10 cycles; no new gw_ap_start until the response is accepted.
- Gateway never asserts ap_done, TIMEOUT_CYCLES=16 -> timeout_error rises 16 cycles after ISSUE and stays high; a late ap_done still completes normally.
- Assert ap_rst_n low mid-WAIT with 3 entries queued -> all outputs 0 immediately (asynchronously); after release busy=0, req_ready=1, and no stale response appears.
